count_stream_checker: RTL and testbench
=======================================

Name: count_stream_checker

Overview:
- Receive-side companion to the free-running 8-bit counter tile output. Samples an 8-bit bus that should carry a +1/cycle incrementing count and locks onto the sequence.
- While locked, flags and counts every deviation. Declares loss of lock after repeated misses.
- Sits behind the tile input pins (ui_in) in a loopback or tile-to-tile test harness.

Parameters:
- LOCK_COUNT, 4: consecutive +1 steps required to enter LOCKED (legal 1..15).
- LOSS_COUNT, 3: consecutive mismatches in LOCKED that force return to SEARCH (legal 1..15).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  sample enable. The bus is sampled only on edges where en=1.
- data_in  input  8  observed count value.
- locked  output  1  registered. 1 while in the LOCKED state.
- err_pulse  output  1  registered. 1 for exactly one cycle after a mismatched sample taken in LOCKED.
- err_count  output  ERR_W  registered. Saturating total of mismatches seen in LOCKED.
- expected  output  8  registered. Value predicted for the next sample; valid when locked=1.

Behaviour:
- Reset (rst_n=0 at an edge) sets:
  - state=SEARCH, locked=0, err_pulse=0, err_count=0, expected=0x00.
  - Internal: prev=0x00, prev_valid=0, run=0, miss=0.
  - Reset has priority over en and applies mid-operation, including while LOCKED.
- en=0: all state holds, and err_pulse is driven 0 on that edge.
- Arithmetic: all +1 operations are modulo 256, so 0xFF->0x00 is a valid step. err_count saturates at 2^ERR_W-1 and never wraps.
- SEARCH, sampled edge (en=1):
  - If prev_valid=1 and data_in == prev+1: run <= run+1. Otherwise run <= 0.
  - prev <= data_in; prev_valid <= 1; expected <= data_in+1.
  - Once run+1 reaches LOCK_COUNT on a matching step: move to LOCKED and set locked <= 1 on that same edge; miss <= 0.
  - The first sample after reset or after loss of lock only primes prev. Lock therefore needs LOCK_COUNT+1 consecutive samples forming LOCK_COUNT steps.
  - err_pulse stays 0 and err_count is unchanged while in SEARCH.
- LOCKED, sampled edge (en=1):
  - Match (data_in == expected): miss <= 0; err_pulse <= 0.
  - Mismatch: err_pulse <= 1; err_count <= sat(err_count+1); miss <= miss+1.
  - Flywheel: expected <= expected+1 on every sampled edge, whether the sample matched or not. The checker does not resync on a single glitch.
  - When a mismatch makes miss reach LOSS_COUNT: on the same edge, state <= SEARCH and locked <= 0. Also run <= 0, prev <= data_in, prev_valid <= 1. err_pulse is still 1 for that mismatch.
- Latency: every output reflects the sample from the previous enabled edge. There are no combinational paths from inputs to outputs.
- A stalled bus (same value repeated) counts as a mismatch in LOCKED and resets run in SEARCH.
- Gaps in en do not advance the prediction. The checker assumes the source counter is gated by the same enable.

Test Plan:
- Lock and track: reset, then en=1 with data_in 0x10,0x11,0x12,0x13,0x14.
  - locked rises after the edge sampling 0x14 (LOCK_COUNT=4); expected=0x15.
  - Continue to 0x20: err_pulse never asserts, err_count stays 0.
- Wrap-around: lock on 0xFB..0xFF, then drive 0x00,0x01 -> locked stays 1, no err_pulse, expected=0x02.
- Single glitch: locked and expecting 0x40, drive 0x40,0x99,0x42,0x43.
  - One err_pulse, in the cycle after the 0x99 sample; err_count=1; locked stays 1.
  - expected=0x44 at the end (flywheel).
- Loss of lock: locked and expecting 0x50, drive 0x00 three times.
  - Three err_pulses; err_count=3; locked falls after the third.
  - Then 0x01,0x02,0x03,0x04 relocks after the 0x04 sample.
- Enable gating and mid-op reset: locked on 0x30..; hold en=0 for 5 cycles with data_in changing to 0xAA.
  - No state change, err_pulse=0.
  - Then en=1 with 0x35 (if expected=0x35) -> no error.
  - Then rst_n=0 for one edge -> locked=0, err_count=0, expected=0x00.
- Saturation: ERR_W=2, hold LOSS_COUNT high (15), lock, then inject 5 mismatches -> err_count stops at 3, err_pulse still fires 5 times.

Source files
------------

// File: rtl/count_stream_checker.sv
// Receive-side checker for an incrementing 8-bit count stream: locks after a run of
// +1 steps, then flags and counts deviations, dropping lock after repeated misses.
//
// state  | meaning
// SEARCH | hunting for LOCK_COUNT consecutive +1 steps; no errors reported
// LOCKED | flywheel prediction running; mismatches pulse and count
module count_stream_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [7:0]       data_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       expected
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);
  localparam logic [3:0]       LOSS_N  = 4'(LOSS_COUNT);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t     state;
  logic [7:0] prev;
  logic       prev_valid;
  logic [3:0] run;
  logic [3:0] miss;

  logic [7:0] prev_inc;
  logic [3:0] run_inc;
  logic [3:0] miss_inc;
  logic       step;
  logic       match;

  assign prev_inc = prev + 8'd1;
  assign run_inc  = run + 4'd1;
  assign miss_inc = miss + 4'd1;
  assign step     = prev_valid && (data_in == prev_inc);
  assign match    = (data_in == expected);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SEARCH;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      expected   <= 8'h00;
      prev       <= 8'h00;
      prev_valid <= 1'b0;
      run        <= 4'd0;
      miss       <= 4'd0;
    end else if (!en) begin
      err_pulse <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          prev       <= data_in;
          prev_valid <= 1'b1;
          expected   <= data_in + 8'd1;
          err_pulse  <= 1'b0;
          if (step) begin
            run <= run_inc;
            if (run_inc == LOCK_N) begin
              state  <= LOCKED;
              locked <= 1'b1;
              miss   <= 4'd0;
            end
          end else begin
            run <= 4'd0;
          end
        end
        LOCKED: begin
          // Prediction free-runs so a single glitch does not drag the checker off sequence
          expected <= expected + 8'd1;
          if (match) begin
            miss      <= 4'd0;
            err_pulse <= 1'b0;
          end else begin
            err_pulse <= 1'b1;
            if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
            miss <= miss_inc;
            if (miss_inc == LOSS_N) begin
              state      <= SEARCH;
              locked     <= 1'b0;
              run        <= 4'd0;
              prev       <= data_in;
              prev_valid <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_stream_checker.sv
// Scoreboard bench for count_stream_checker: default instance plus a narrow-counter,
// high-loss-threshold instance for saturation.
module tb_count_stream_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] data_in;

  logic       locked_a, err_pulse_a;
  logic [7:0] err_count_a, expected_a;
  logic       locked_b, err_pulse_b;
  logic [1:0] err_count_b;
  logic [7:0] expected_b;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit         which;
    string      name;
    logic       lk;
    logic       ep;
    logic [7:0] ec;
    logic [7:0] ex;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  count_stream_checker dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in),
    .locked(locked_a), .err_pulse(err_pulse_a), .err_count(err_count_a), .expected(expected_a)
  );

  count_stream_checker #(.LOCK_COUNT(4), .LOSS_COUNT(15), .ERR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in),
    .locked(locked_b), .err_pulse(err_pulse_b), .err_count(err_count_b), .expected(expected_b)
  );

  // Drive one edge, queue the expected post-edge outputs, then compare after the edge.
  task automatic drive(input bit which, input string name, input logic r, input logic e,
                       input logic [7:0] d, input logic lk, input logic ep,
                       input logic [7:0] ec, input logic [7:0] ex);
    exp_t item;
    exp_t got;
    logic       o_lk, o_ep;
    logic [7:0] o_ec, o_ex;
    rst_n   = r;
    en      = e;
    data_in = d;
    item.which = which; item.name = name;
    item.lk = lk; item.ep = ep; item.ec = ec; item.ex = ex;
    sb.push_back(item);
    @(posedge clk);
    #1;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = sb.pop_front();
      if (got.which) begin
        o_lk = locked_b; o_ep = err_pulse_b; o_ec = {6'd0, err_count_b}; o_ex = expected_b;
      end else begin
        o_lk = locked_a; o_ep = err_pulse_a; o_ec = err_count_a; o_ex = expected_a;
      end
      if (o_lk !== got.lk || o_ep !== got.ep || o_ec !== got.ec || o_ex !== got.ex) begin
        miscompares++;
        $display("FAIL %s data=%h: got locked=%b err_pulse=%b err_count=%0d expected=%h, want locked=%b err_pulse=%b err_count=%0d expected=%h",
                 got.name, d, o_lk, o_ep, o_ec, o_ex, got.lk, got.ep, got.ec, got.ex);
      end
    end
  endtask

  // Reset then lock on base..base+4; leaves the prediction at base+5.
  task automatic reset_and_lock(input bit which, input logic [7:0] base);
    logic [7:0] d;
    drive(which, "reset", 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'd0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      d = base + 8'(i);
      drive(which, "lock", 1'b1, 1'b1, d, (i == 4), 1'b0, 8'd0, d + 8'd1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; data_in = 8'h00;
    drive(1'b0, "reset_a", 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'd0, 8'h00);
    drive(1'b1, "reset_b", 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 8'd0, 8'h00);
  endtask

  task automatic test_lock_track();
    logic [7:0] d;
    drive(1'b0, "reset", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0, 8'h00);
    for (int i = 0; i <= 16; i++) begin
      d = 8'h10 + 8'(i);
      drive(1'b0, "lock_track", 1'b1, 1'b1, d, (d >= 8'h14), 1'b0, 8'd0, d + 8'd1);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    drive(1'b0, "reset", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0, 8'h00);
    for (int i = 0; i < 7; i++) begin
      d = 8'hFB + 8'(i);
      drive(1'b0, "wrap", 1'b1, 1'b1, d, (i >= 4), 1'b0, 8'd0, d + 8'd1);
    end
  endtask

  task automatic test_glitch();
    reset_and_lock(1'b0, 8'h3B);
    drive(1'b0, "glitch_pre",  1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 8'd0, 8'h41);
    drive(1'b0, "glitch_bad",  1'b1, 1'b1, 8'h99, 1'b1, 1'b1, 8'd1, 8'h42);
    drive(1'b0, "glitch_rec1", 1'b1, 1'b1, 8'h42, 1'b1, 1'b0, 8'd1, 8'h43);
    drive(1'b0, "glitch_rec2", 1'b1, 1'b1, 8'h43, 1'b1, 1'b0, 8'd1, 8'h44);
  endtask

  task automatic test_loss();
    reset_and_lock(1'b0, 8'h4B);
    drive(1'b0, "loss_miss1", 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'd1, 8'h51);
    drive(1'b0, "loss_miss2", 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'd2, 8'h52);
    drive(1'b0, "loss_miss3", 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'd3, 8'h53);
    drive(1'b0, "relock1", 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 8'd3, 8'h02);
    drive(1'b0, "relock2", 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 8'd3, 8'h03);
    drive(1'b0, "relock3", 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 8'd3, 8'h04);
    drive(1'b0, "relock4", 1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 8'd3, 8'h05);
  endtask

  task automatic test_enable_gating();
    reset_and_lock(1'b0, 8'h30);
    drive(1'b0, "gate_glitch", 1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 8'd1, 8'h36);
    for (int i = 0; i < 5; i++)
      drive(1'b0, "gate_hold", 1'b1, 1'b0, 8'hAA + 8'(i), 1'b1, 1'b0, 8'd1, 8'h36);
    drive(1'b0, "gate_resume", 1'b1, 1'b1, 8'h36, 1'b1, 1'b0, 8'd1, 8'h37);
    drive(1'b0, "midop_reset", 1'b0, 1'b1, 8'h37, 1'b0, 1'b0, 8'd0, 8'h00);
    // Stall inside SEARCH must restart the run count
    drive(1'b0, "stall_prime", 1'b1, 1'b1, 8'h38, 1'b0, 1'b0, 8'd0, 8'h39);
    drive(1'b0, "stall_step",  1'b1, 1'b1, 8'h39, 1'b0, 1'b0, 8'd0, 8'h3A);
    drive(1'b0, "stall_rep",   1'b1, 1'b1, 8'h39, 1'b0, 1'b0, 8'd0, 8'h3A);
    drive(1'b0, "stall_s1",    1'b1, 1'b1, 8'h3A, 1'b0, 1'b0, 8'd0, 8'h3B);
    drive(1'b0, "stall_s2",    1'b1, 1'b1, 8'h3B, 1'b0, 1'b0, 8'd0, 8'h3C);
    drive(1'b0, "stall_s3",    1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 8'd0, 8'h3D);
    drive(1'b0, "stall_lock",  1'b1, 1'b1, 8'h3D, 1'b1, 1'b0, 8'd0, 8'h3E);
  endtask

  task automatic test_saturation();
    logic [7:0] cnt;
    reset_and_lock(1'b1, 8'h60);
    for (int i = 0; i < 5; i++) begin
      cnt = (i >= 2) ? 8'd3 : 8'(i + 1);
      drive(1'b1, "sat_miss", 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, cnt, 8'h66 + 8'(i));
    end
    drive(1'b1, "sat_match", 1'b1, 1'b1, 8'h6A, 1'b1, 1'b0, 8'd3, 8'h6B);
  endtask

  initial begin
    test_reset();
    test_lock_track();
    test_wrap();
    test_glitch();
    test_loss();
    test_enable_gating();
    test_saturation();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
